cuckoo_ctrl: RTL and testbench

Command sequencer for a two-table cuckoo hash store holding KEY_W-bit keys. Accepts search/insert/delete commands over a valid/ready handshake. Runs the bounded displacement (kick) loop one placement per cycle and returns a status response over a second valid/ready handshake. Owns both tables and their valid bits, and is the single access point to them for the surrounding blockchain datapath.

---
 rtl/cuckoo_ctrl.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_cuckoo_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cuckoo_ctrl.sv
// cuckoo_ctrl: command sequencer owning a two-table cuckoo hash store with a bounded kick loop.
// Optional macro CUCKOO_STATS_EN adds saturating eviction (stat_kicks) and failure (stat_fails) counters.
module cuckoo_ctrl #(
    parameter  int KEY_W     = 32,
    parameter  int SLOTS     = 10,
    parameter  int MAX_KICKS = 20,
    localparam int IDX_W     = $clog2(SLOTS),
    localparam int OCC_W     = $clog2(2 * SLOTS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [KEY_W-1:0] cmd_key,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_status,
    output logic             rsp_table,
    output logic [IDX_W-1:0] rsp_index,
    output logic [KEY_W-1:0] rsp_key,
`ifdef CUCKOO_STATS_EN
    output logic [31:0]      stat_kicks,
    output logic [15:0]      stat_fails,
`endif
    output logic [OCC_W-1:0] occupancy
);

    localparam int KICK_W = $clog2(MAX_KICKS + 2);
    localparam logic [KICK_W-1:0] KICK_MAX = KICK_W'(MAX_KICKS);

    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_DELETE = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_NOT_FOUND = 2'b01;
    localparam logic [1:0] ST_FULL      = 2'b10;
    localparam logic [1:0] ST_BAD_OP    = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        PLACE_T1 = 3'd2,
        PLACE_T2 = 3'd3,
        RESP     = 3'd4
    } state_t;

    function automatic logic [IDX_W-1:0] hash1(input logic [KEY_W-1:0] k);
        return IDX_W'(k % KEY_W'(SLOTS));
    endfunction

    // 3*k is formed at KEY_W+2 bits so the multiply never wraps before the modulo.
    function automatic logic [IDX_W-1:0] hash2(input logic [KEY_W-1:0] k);
        logic [KEY_W+1:0] triple;
        triple = {2'b00, k} * (KEY_W + 2)'(3);
        return IDX_W'(triple % (KEY_W + 2)'(SLOTS));
    endfunction

    state_t             state_r, state_nxt_s;
    logic [1:0]         op_r;
    logic [KEY_W-1:0]   key_r, carry_r;
    logic [KICK_W-1:0]  kicks_r;
    logic               cmd_ready_r, rsp_valid_r;
    logic [1:0]         rsp_status_r;
    logic               rsp_table_r;
    logic [IDX_W-1:0]   rsp_index_r;
    logic [KEY_W-1:0]   rsp_key_r;
    logic [OCC_W-1:0]   occ_r;

    logic [KEY_W-1:0]   t1_key_r [SLOTS];
    logic [KEY_W-1:0]   t2_key_r [SLOTS];
    logic [SLOTS-1:0]   t1_vld_r, t2_vld_r;

    logic [IDX_W-1:0]   lk_h1_s, lk_h2_s, pl_h1_s, pl_h2_s;
    logic               hit1_s, hit2_s;
    logic               pl_active_s, pl_occ_s, can_kick_s, do_write_s, first_s;
    logic [KEY_W-1:0]   pl_old_s;
    logic               cmd_fire_s, rsp_fire_s;

    // Probe decode for LOOKUP and placement target decode for the PLACE states.
    always_comb begin
        lk_h1_s     = hash1(key_r);
        lk_h2_s     = hash2(key_r);
        hit1_s      = t1_vld_r[lk_h1_s] && (t1_key_r[lk_h1_s] == key_r);
        hit2_s      = t2_vld_r[lk_h2_s] && (t2_key_r[lk_h2_s] == key_r);
        pl_h1_s     = hash1(carry_r);
        pl_h2_s     = hash2(carry_r);
        pl_active_s = (state_r == PLACE_T1) || (state_r == PLACE_T2);
        if (state_r == PLACE_T2) begin
            pl_occ_s = t2_vld_r[pl_h2_s];
            pl_old_s = t2_key_r[pl_h2_s];
        end else begin
            pl_occ_s = t1_vld_r[pl_h1_s];
            pl_old_s = t1_key_r[pl_h1_s];
        end
        can_kick_s  = (kicks_r != KICK_MAX);
        do_write_s  = pl_active_s && (!pl_occ_s || can_kick_s);
        first_s     = (state_r == PLACE_T1) && (kicks_r == KICK_W'(0));
        cmd_fire_s  = cmd_valid && cmd_ready_r;
        rsp_fire_s  = rsp_valid_r && rsp_ready;
    end

    // Next-state logic of the command FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (cmd_fire_s) begin
                    state_nxt_s = (cmd_op == OP_RSVD) ? RESP : LOOKUP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOOKUP: begin
                if ((op_r == OP_INSERT) && !hit1_s && !hit2_s) begin
                    state_nxt_s = PLACE_T1;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            PLACE_T1: begin
                if (pl_occ_s && can_kick_s) begin
                    state_nxt_s = PLACE_T2;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            PLACE_T2: begin
                if (pl_occ_s && can_kick_s) begin
                    state_nxt_s = PLACE_T1;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            RESP: begin
                if (rsp_fire_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register with handshake flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cmd_ready_r <= (state_nxt_s == IDLE);
            rsp_valid_r <= (state_nxt_s == RESP);
        end
    end

    // Command latch, kick loop carry and response field registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r         <= 2'b00;
            key_r        <= {KEY_W{1'b0}};
            carry_r      <= {KEY_W{1'b0}};
            kicks_r      <= KICK_W'(0);
            rsp_status_r <= 2'b00;
            rsp_table_r  <= 1'b0;
            rsp_index_r  <= IDX_W'(0);
            rsp_key_r    <= {KEY_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_fire_s) begin
                        op_r         <= cmd_op;
                        key_r        <= cmd_key;
                        rsp_key_r    <= cmd_key;
                        rsp_table_r  <= 1'b0;
                        rsp_index_r  <= IDX_W'(0);
                        rsp_status_r <= (cmd_op == OP_RSVD) ? ST_BAD_OP : ST_OK;
                    end
                end
                LOOKUP: begin
                    carry_r <= key_r;
                    kicks_r <= KICK_W'(0);
                    if (hit1_s) begin
                        rsp_status_r <= ST_OK;
                        rsp_table_r  <= 1'b0;
                        rsp_index_r  <= lk_h1_s;
                    end else if (hit2_s) begin
                        rsp_status_r <= ST_OK;
                        rsp_table_r  <= 1'b1;
                        rsp_index_r  <= lk_h2_s;
                    end else begin
                        rsp_status_r <= (op_r == OP_INSERT) ? ST_OK : ST_NOT_FOUND;
                    end
                end
                PLACE_T1, PLACE_T2: begin
                    // Only the very first placement holds the command key itself.
                    if (first_s && do_write_s) begin
                        rsp_table_r <= 1'b0;
                        rsp_index_r <= pl_h1_s;
                    end
                    if (!pl_occ_s) begin
                        rsp_status_r <= ST_OK;
                    end else if (can_kick_s) begin
                        carry_r <= pl_old_s;
                        kicks_r <= kicks_r + KICK_W'(1);
                    end else begin
                        rsp_status_r <= ST_FULL;
                        rsp_key_r    <= carry_r;
                    end
                end
                default: ;
            endcase
        end
    end

    // Table contents, valid bits and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                t1_key_r[i] <= {KEY_W{1'b0}};
                t2_key_r[i] <= {KEY_W{1'b0}};
            end
            t1_vld_r <= {SLOTS{1'b0}};
            t2_vld_r <= {SLOTS{1'b0}};
            occ_r    <= OCC_W'(0);
        end else begin
            case (state_r)
                LOOKUP: begin
                    if ((op_r == OP_DELETE) && hit1_s) begin
                        t1_vld_r[lk_h1_s] <= 1'b0;
                        occ_r             <= occ_r - OCC_W'(1);
                    end else if ((op_r == OP_DELETE) && hit2_s) begin
                        t2_vld_r[lk_h2_s] <= 1'b0;
                        occ_r             <= occ_r - OCC_W'(1);
                    end
                end
                PLACE_T1: begin
                    if (do_write_s) begin
                        t1_key_r[pl_h1_s] <= carry_r;
                        t1_vld_r[pl_h1_s] <= 1'b1;
                    end
                    if (!pl_occ_s) begin
                        occ_r <= occ_r + OCC_W'(1);
                    end
                end
                PLACE_T2: begin
                    if (do_write_s) begin
                        t2_key_r[pl_h2_s] <= carry_r;
                        t2_vld_r[pl_h2_s] <= 1'b1;
                    end
                    if (!pl_occ_s) begin
                        occ_r <= occ_r + OCC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CUCKOO_STATS_EN
    logic [31:0] stat_kicks_r;
    logic [15:0] stat_fails_r;

    // Saturating counters of evictions and FULL outcomes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_kicks_r <= 32'd0;
            stat_fails_r <= 16'd0;
        end else if (pl_active_s && pl_occ_s) begin
            if (can_kick_s) begin
                if (stat_kicks_r != 32'hFFFF_FFFF) begin
                    stat_kicks_r <= stat_kicks_r + 32'd1;
                end
            end else if (stat_fails_r != 16'hFFFF) begin
                stat_fails_r <= stat_fails_r + 16'd1;
            end
        end
    end

    assign stat_kicks = stat_kicks_r;
    assign stat_fails = stat_fails_r;
`endif

    assign cmd_ready  = cmd_ready_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_status = rsp_status_r;
    assign rsp_table  = rsp_table_r;
    assign rsp_index  = rsp_index_r;
    assign rsp_key    = rsp_key_r;
    assign occupancy  = occ_r;

endmodule

// File: tb/tb_cuckoo_ctrl.sv
// tb_cuckoo_ctrl: table-driven check of cuckoo_ctrl (default build and a MAX_KICKS=2 instance)
// plus hand-written backpressure and mid-insert reset sequences.
module tb_cuckoo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        cmd_valid, rsp_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_key;

    logic        a_cmd_ready, a_rsp_valid, a_rsp_table;
    logic [1:0]  a_rsp_status;
    logic [3:0]  a_rsp_index;
    logic [31:0] a_rsp_key;
    logic [4:0]  a_occ;
    logic        b_cmd_ready, b_rsp_valid, b_rsp_table;
    logic [1:0]  b_rsp_status;
    logic [3:0]  b_rsp_index;
    logic [31:0] b_rsp_key;
    logic [4:0]  b_occ;
`ifdef CUCKOO_STATS_EN
    logic [31:0] a_stat_kicks, b_stat_kicks;
    logic [15:0] a_stat_fails, b_stat_fails;
`endif

    logic        o_cmd_ready, o_rsp_valid, o_rsp_table;
    logic [1:0]  o_rsp_status;
    logic [3:0]  o_rsp_index;
    logic [31:0] o_rsp_key;
    logic [4:0]  o_occ;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cuckoo_ctrl dut_a (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid && !sel), .cmd_ready(a_cmd_ready),
        .cmd_op(cmd_op), .cmd_key(cmd_key),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready && !sel),
        .rsp_status(a_rsp_status), .rsp_table(a_rsp_table),
        .rsp_index(a_rsp_index), .rsp_key(a_rsp_key),
`ifdef CUCKOO_STATS_EN
        .stat_kicks(a_stat_kicks), .stat_fails(a_stat_fails),
`endif
        .occupancy(a_occ)
    );

    cuckoo_ctrl #(.MAX_KICKS(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid && sel), .cmd_ready(b_cmd_ready),
        .cmd_op(cmd_op), .cmd_key(cmd_key),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready && sel),
        .rsp_status(b_rsp_status), .rsp_table(b_rsp_table),
        .rsp_index(b_rsp_index), .rsp_key(b_rsp_key),
`ifdef CUCKOO_STATS_EN
        .stat_kicks(b_stat_kicks), .stat_fails(b_stat_fails),
`endif
        .occupancy(b_occ)
    );

    always_comb begin
        if (sel) begin
            o_cmd_ready  = b_cmd_ready;  o_rsp_valid = b_rsp_valid;
            o_rsp_status = b_rsp_status; o_rsp_table = b_rsp_table;
            o_rsp_index  = b_rsp_index;  o_rsp_key   = b_rsp_key;
            o_occ        = b_occ;
        end else begin
            o_cmd_ready  = a_cmd_ready;  o_rsp_valid = a_rsp_valid;
            o_rsp_status = a_rsp_status; o_rsp_table = a_rsp_table;
            o_rsp_index  = a_rsp_index;  o_rsp_key   = a_rsp_key;
            o_occ        = a_occ;
        end
    end

    typedef struct {
        logic        sel;
        logic [1:0]  op;
        logic [31:0] key;
        int          hold;
        logic [1:0]  st;
        logic        chk_loc;
        logic        tbl;
        logic [3:0]  idx;
        logic [31:0] rkey;
        int          cyc;   // N+cyc latency; 0 = not checked
        int          occ;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        int lat;
        sel       = v.sel;
        cmd_op    = v.op;
        cmd_key   = v.key;
        cmd_valid = 1'b1;
        n = 0;
        while (o_cmd_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("cmd_ready_idle", 32'(o_cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0;
        while (o_rsp_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        chk("rsp_valid", 32'(o_rsp_valid), 32'd1);
        if (v.cyc != 0) chk("latency", 32'(lat + 1), 32'(v.cyc));
        for (int h = 0; h <= v.hold; h++) begin
            chk("cmd_ready_busy", 32'(o_cmd_ready), 32'd0);
            chk("rsp_valid_held", 32'(o_rsp_valid), 32'd1);
            chk("rsp_status", 32'(o_rsp_status), 32'(v.st));
            chk("rsp_key", o_rsp_key, v.rkey);
            if (v.chk_loc) begin
                chk("rsp_table", 32'(o_rsp_table), 32'(v.tbl));
                chk("rsp_index", 32'(o_rsp_index), 32'(v.idx));
            end
            if (h < v.hold) begin
                @(posedge clk); #1;
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(o_rsp_valid), 32'd0);
        chk("occupancy", 32'(o_occ), 32'(v.occ));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //          sel   op     key     hold st     loc   tbl   idx   rkey    cyc occ
        vecs[0]  = '{1'b0, 2'b00, 32'd5,  0, 2'b01, 1'b0, 1'b0, 4'd0, 32'd5,  2, 0};
        vecs[1]  = '{1'b0, 2'b01, 32'd7,  0, 2'b00, 1'b1, 1'b0, 4'd7, 32'd7,  3, 1};
        vecs[2]  = '{1'b0, 2'b00, 32'd7,  0, 2'b00, 1'b1, 1'b0, 4'd7, 32'd7,  2, 1};
        vecs[3]  = '{1'b0, 2'b01, 32'd17, 0, 2'b00, 1'b1, 1'b0, 4'd7, 32'd17, 4, 2};
        vecs[4]  = '{1'b0, 2'b00, 32'd7,  0, 2'b00, 1'b1, 1'b1, 4'd1, 32'd7,  2, 2};
        vecs[5]  = '{1'b0, 2'b01, 32'd7,  0, 2'b00, 1'b1, 1'b1, 4'd1, 32'd7,  0, 2};
        vecs[6]  = '{1'b0, 2'b00, 32'd17, 0, 2'b00, 1'b1, 1'b0, 4'd7, 32'd17, 2, 2};
        vecs[7]  = '{1'b0, 2'b11, 32'd9,  0, 2'b11, 1'b0, 1'b0, 4'd0, 32'd9,  1, 2};
        vecs[8]  = '{1'b0, 2'b10, 32'd5,  0, 2'b01, 1'b0, 1'b0, 4'd0, 32'd5,  2, 2};
        vecs[9]  = '{1'b0, 2'b01, 32'd3,  0, 2'b00, 1'b1, 1'b0, 4'd3, 32'd3,  3, 3};
        vecs[10] = '{1'b0, 2'b01, 32'd13, 0, 2'b00, 1'b1, 1'b0, 4'd3, 32'd13, 4, 4};
        vecs[11] = '{1'b0, 2'b00, 32'd3,  0, 2'b00, 1'b1, 1'b1, 4'd9, 32'd3,  2, 4};
        vecs[12] = '{1'b0, 2'b10, 32'd7,  0, 2'b00, 1'b1, 1'b1, 4'd1, 32'd7,  2, 3};
        vecs[13] = '{1'b0, 2'b00, 32'd7,  0, 2'b01, 1'b0, 1'b0, 4'd0, 32'd7,  2, 3};
        vecs[14] = '{1'b0, 2'b10, 32'd17, 5, 2'b00, 1'b1, 1'b0, 4'd7, 32'd17, 2, 2};
        vecs[15] = '{1'b0, 2'b00, 32'd17, 0, 2'b01, 1'b0, 1'b0, 4'd0, 32'd17, 2, 2};
        vecs[16] = '{1'b1, 2'b01, 32'd7,  0, 2'b00, 1'b1, 1'b0, 4'd7, 32'd7,  3, 1};
        vecs[17] = '{1'b1, 2'b01, 32'd17, 0, 2'b00, 1'b1, 1'b0, 4'd7, 32'd17, 4, 2};
        vecs[18] = '{1'b1, 2'b01, 32'd27, 0, 2'b10, 1'b1, 1'b0, 4'd7, 32'd7,  5, 2};
        vecs[19] = '{1'b1, 2'b00, 32'd27, 0, 2'b00, 1'b1, 1'b0, 4'd7, 32'd27, 2, 2};
        vecs[20] = '{1'b1, 2'b00, 32'd17, 0, 2'b00, 1'b1, 1'b1, 4'd1, 32'd17, 2, 2};
        vecs[21] = '{1'b1, 2'b00, 32'd7,  0, 2'b01, 1'b0, 1'b0, 4'd0, 32'd7,  2, 2};

        rst_n = 1'b0; sel = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = 2'b00; cmd_key = 32'd0;
        #12;
        chk("reset_cmd_ready", 32'(o_cmd_ready), 32'd1);
        chk("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("reset_occupancy", 32'(o_occ), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 22; i++) begin
            run_vec(vecs[i]);
        end

        // Reset asserted while a kicking insert of 23 sits in PLACE_T2 (T1[3]=13, T2[9]=3).
        sel = 1'b0; cmd_op = 2'b01; cmd_key = 32'd23; cmd_valid = 1'b1;
        chk("mid_cmd_ready", 32'(o_cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_rsp_valid", 32'(o_rsp_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst_rsp_status", 32'(o_rsp_status), 32'd0);
        chk("rst_rsp_table", 32'(o_rsp_table), 32'd0);
        chk("rst_rsp_index", 32'(o_rsp_index), 32'd0);
        chk("rst_rsp_key", o_rsp_key, 32'd0);
        chk("rst_occupancy", 32'(o_occ), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        v = '{1'b0, 2'b00, 32'd13, 0, 2'b01, 1'b0, 1'b0, 4'd0, 32'd13, 2, 0};
        run_vec(v);
        v = '{1'b0, 2'b00, 32'd3,  0, 2'b01, 1'b0, 1'b0, 4'd0, 32'd3,  2, 0};
        run_vec(v);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
